voter_ballot_collector: RTL

Upstream stage of the 4-voter decision path. The block opens a voting session on `start_i` and records one ballot per voter, first vote wins. It closes the session when all four voters have voted or a timeout expires, then holds the 4-bit ballot vector with a valid/ready handshake. The downstream majority classifier consumes `ballot_o` directly as its 4-bit input.

---
 rtl/voter_pkg.sv | 17 +
 rtl/voter_timeout_timer.sv | 27 ++
 rtl/voter_ballot_collector.sv | 97 +++++++++
 3 files changed

// File: rtl/voter_pkg.sv
// Shared types and constants for the 4-voter decision path.
package voter_pkg;

    localparam int unsigned N_VOTERS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } vote_state_e;

    // One-hot result codes of the downstream majority classifier.
    localparam logic [2:0] RES_FAIL = 3'b100;
    localparam logic [2:0] RES_TIE  = 3'b010;
    localparam logic [2:0] RES_PASS = 3'b001;

endpackage

// File: rtl/voter_timeout_timer.sv
// COLLECT-phase cycle counter; flags the final permitted cycle of a session.
module voter_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST) & en;

endmodule

// File: rtl/voter_ballot_collector.sv
// Opens a voting session on start_i, records first vote per voter, and presents
// the ballot with a valid/ready handshake once all have voted or time runs out.
module voter_ballot_collector #(
    parameter int unsigned N_VOTERS       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [N_VOTERS-1:0] vote_valid_i,
    input  logic [N_VOTERS-1:0] vote_val_i,
    output logic [N_VOTERS-1:0] ballot_o,
    output logic                ballot_valid_o,
    input  logic                ballot_ready_i,
    output logic [N_VOTERS-1:0] voted_o,
    output logic                timeout_o,
    output logic                busy_o
);

    import voter_pkg::*;

    vote_state_e state_q;

    logic                timer_clr;
    logic                timer_en;
    logic                expired;
    logic [N_VOTERS-1:0] voted_next;
    logic                all_voted;

    assign timer_clr  = (state_q == IDLE) && start_i;
    assign timer_en   = (state_q == COLLECT);
    // Includes this cycle's new votes, so a vote in the expiry cycle wins over timeout.
    assign voted_next = voted_o | vote_valid_i;
    assign all_voted  = &voted_next;

    voter_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ballot_o       <= '0;
            voted_o        <= '0;
            ballot_valid_o <= 1'b0;
            timeout_o      <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q   <= COLLECT;
                        ballot_o  <= '0;
                        voted_o   <= '0;
                        timeout_o <= 1'b0;
                        busy_o    <= 1'b1;
                    end
                end
                COLLECT: begin
                    for (int unsigned i = 0; i < N_VOTERS; i++) begin
                        if (vote_valid_i[i] && !voted_o[i]) begin
                            ballot_o[i] <= vote_val_i[i];
                            voted_o[i]  <= 1'b1;
                        end
                    end
                    if (all_voted) begin
                        state_q        <= PRESENT;
                        ballot_valid_o <= 1'b1;
                    end else if (expired) begin
                        state_q        <= PRESENT;
                        ballot_valid_o <= 1'b1;
                        timeout_o      <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (ballot_ready_i) begin
                        state_q        <= IDLE;
                        ballot_valid_o <= 1'b0;
                        busy_o         <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    ballot_valid_o <= 1'b0;
                    busy_o         <= 1'b0;
                end
            endcase
        end
    end

endmodule
